multicycle_seq: RTL and testbench
=================================

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the bus-wait limit in cycles (8-bit, 1..255); it is used only when MC_BUS_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request.
REQ-005 SHALL have port imem_ready  input  1  fetch data valid this cycle.
REQ-006 SHALL have port dmem_req  output  1  data memory request.
REQ-007 SHALL have port dmem_we  output  1  data request is a write.
REQ-008 SHALL have port dmem_ready  input  1  data access complete this cycle.
REQ-009 SHALL have ports dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump  input  1 each  decoded controls for the current IR, valid from DECODE onward.
REQ-010 SHALL have port dec_illegal  input  1  unrecognised opcode.
REQ-011 SHALL have port ir_write  output  1  latch the fetched instruction.
REQ-012 SHALL have port pc_write  output  1  update PC (the datapath selects PC+4 or the target).
REQ-013 SHALL have port rf_write  output  1  register file write enable.
REQ-014 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-015 SHALL have port state  output  3  current state encoding.
REQ-016 SHALL have port fault  output  1  sticky fault indicator.

Function
REQ-017 SHALL use the state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; encodings 6 and 7 SHALL go to FAULT on the next edge.
REQ-018 SHALL drive all outputs combinationally from the state and inputs (Moore/Mealy mix as listed); every output not listed for a state SHALL be 0.
REQ-019 FETCH: imem_req=1; when imem_ready=1, assert ir_write=1 and go to DECODE, otherwise stay in FETCH.
REQ-020 DECODE: single cycle; go to FAULT if dec_illegal=1, or if dec_mem_read and dec_mem_write are both 1; otherwise go to EXEC.
REQ-021 EXEC: single cycle, with the following transitions:
- if dec_mem_read or dec_mem_write is 1, go to MEM;
- else if dec_branch=1, assert pc_write=1 and retire=1 and go to FETCH;
- else go to WB.
REQ-022 MEM: dmem_req=1 and dmem_we=dec_mem_write; hold both stable until dmem_ready=1. On dmem_ready=1:
- a store asserts pc_write=1 and retire=1 and goes to FETCH;
- a load goes to WB.
REQ-023 WB: rf_write=dec_reg_write, pc_write=1, retire=1; go to FETCH (this covers ALU, LUI, AUIPC, JAL, JALR and loads).
REQ-024 FAULT: fault=1, all request and write outputs 0; FAULT is absorbing until reset.
REQ-025 With zero-wait memory, latency SHALL be: branch 3 cycles, ALU/jump 4, store 4, load 5; each wait cycle adds 1.
REQ-026 retire, pc_write and rf_write SHALL each be asserted at most once per instruction, and never outside the cycles given in REQ-021 to REQ-023.
REQ-027 A ready input asserted in a state that does not request it SHALL be ignored.

Reset
REQ-028 Asserting reset SHALL immediately force state=FETCH, fault=0 and the timeout counter to 0, regardless of the clock.
REQ-029 On the first rising clk edge after reset deasserts, FETCH behaviour applies; imem_req=1 is visible combinationally during reset, and the memory ignores it while reset is high.
REQ-030 Reset asserted mid-access (MEM or FETCH) SHALL abandon the access with no retire, pc_write or rf_write.

Configuration
REQ-031 Macro MC_BUS_TIMEOUT_EN, when defined:
- an 8-bit counter SHALL increment each cycle in FETCH or MEM while the corresponding ready is 0;
- the counter SHALL clear on any state change or ready;
- when the counter equals TIMEOUT_CYCLES, the next state SHALL be FAULT.
REQ-032 When MC_BUS_TIMEOUT_EN is undefined, there SHALL be no counter, waits SHALL be unbounded, and FAULT SHALL be reachable only via REQ-017 and REQ-020.

Verification
REQ-033 ADDI with imem_ready tied to 1 -> states 0,1,2,4,0; rf_write=1 and retire=1 in cycle 4 only.
REQ-034 LW with dmem_ready delayed 3 cycles -> MEM held for 4 cycles with dmem_req=1 and dmem_we=0; WB follows; total 8 cycles; retire pulses once.
REQ-035 SW then BEQ, zero-wait -> SW: MEM with dmem_we=1, retire on the 4th cycle, no rf_write; BEQ: pc_write and retire in EXEC, 3 cycles.
REQ-036 dec_illegal=1 in DECODE -> state=5, fault=1 and stays there for 100 cycles; reset clears it to state=0 and fault=0.
REQ-037 With MC_BUS_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, imem_ready held at 0 -> FAULT is entered after 5 FETCH cycles; with the macro undefined, FETCH holds for 1000 cycles.
REQ-038 Reset pulsed asynchronously in MEM while dmem_ready=0 -> state=0 before the next edge, with no retire, rf_write or pc_write.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB plus a sticky FAULT.
// Optional bus-wait timeout is enabled by defining MC_BUS_TIMEOUT_EN.
module multicycle_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  input  logic       dec_reg_write,
  input  logic       dec_mem_read,
  input  logic       dec_mem_write,
  input  logic       dec_branch,
  input  logic       dec_jump,
  input  logic       dec_illegal,
  output logic       ir_write,
  output logic       pc_write,
  output logic       rf_write,
  output logic       retire,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_e state_q;
  state_e state_d;
  logic   tmo_hit;
  logic   unused_ok;

  // Jumps need no special sequencing: they retire through WB like ALU ops.
  assign unused_ok = dec_jump;

`ifdef MC_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_q;
  logic [7:0] tmo_d;
  logic       waiting;

  // A bus wait is a requesting state whose ready is still low.
  always_comb begin
    waiting = 1'b0;
    if (state_q == S_FETCH) waiting = !imem_ready;
    if (state_q == S_MEM)   waiting = !dmem_ready;
    tmo_hit = waiting && (tmo_q == TMO_LIMIT);
    tmo_d   = (waiting && !tmo_hit) ? tmo_q + 8'd1 : 8'd0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state and the Mealy/Moore control outputs.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_write = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_write = 1'b0;
    rf_write = 1'b0;
    retire   = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_hit) begin
          state_d  = S_FAULT;
        end
      end
      S_DECODE: begin
        if (dec_illegal || (dec_mem_read && dec_mem_write))
          state_d = S_FAULT;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          state_d  = S_MEM;
        end else if (dec_branch) begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ready) begin
          if (dec_mem_write) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end else if (tmo_hit) begin
          state_d  = S_FAULT;
        end
      end
      S_WB: begin
        rf_write = dec_reg_write;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_FAULT: begin
        fault   = 1'b1;
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign state = state_q;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
`ifdef MC_BUS_TIMEOUT_EN
      tmo_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MC_BUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: per-cycle expected outputs are queued
// when inputs are driven and popped when the outputs are sampled.
module tb_multicycle_seq;

  localparam logic [7:0] IREQ = 8'h80;
  localparam logic [7:0] IRW  = 8'h40;
  localparam logic [7:0] DREQ = 8'h20;
  localparam logic [7:0] DWE  = 8'h10;
  localparam logic [7:0] PCW  = 8'h08;
  localparam logic [7:0] RFW  = 8'h04;
  localparam logic [7:0] RET  = 8'h02;
  localparam logic [7:0] FLT  = 8'h01;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req, imem_ready;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       dec_reg_write, dec_mem_read, dec_mem_write;
  logic       dec_branch, dec_jump, dec_illegal;
  logic       ir_write, pc_write, rf_write, retire, fault;
  logic [2:0] state;
  logic [10:0] obs;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  multicycle_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_branch(dec_branch),
    .dec_jump(dec_jump), .dec_illegal(dec_illegal),
    .ir_write(ir_write), .pc_write(pc_write), .rf_write(rf_write),
    .retire(retire), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {state, imem_req, ir_write, dmem_req, dmem_we,
                pc_write, rf_write, retire, fault};

  task automatic push(input string tag, input logic [2:0] st,
                      input logic [7:0] fl);
    sb_t e;
    e.tag = tag;
    e.exp = {st, fl};
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    sb_t e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  // Drive one cycle of inputs, sample at the falling edge.
  task automatic step(input string tag, input logic ir, input logic dr,
                      input logic [2:0] st, input logic [7:0] fl);
    imem_ready = ir;
    dmem_ready = dr;
    push(tag, st, fl);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic rw, input logic mr, input logic mw,
                         input logic br, input logic jp, input logic il);
    dec_reg_write = rw;
    dec_mem_read  = mr;
    dec_mem_write = mw;
    dec_branch    = br;
    dec_jump      = jp;
    dec_illegal   = il;
  endtask

  task automatic do_reset(input string tag);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    push(tag, 3'd0, IREQ);
    pop_check();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("rst_state", 0, 0, 3'd0, IREQ);
    reset = 1'b0;

    // ADDI, zero-wait fetch
    set_dec(1, 0, 0, 0, 0, 0);
    step("addi_f", 1, 0, 3'd0, IREQ | IRW);
    step("addi_d", 1, 0, 3'd1, 8'h00);
    step("addi_e", 1, 0, 3'd2, 8'h00);
    step("addi_w", 1, 0, 3'd4, PCW | RFW | RET);

    // LW, three dmem wait cycles; stray readies ignored
    set_dec(1, 1, 0, 0, 0, 0);
    step("lw_f", 1, 0, 3'd0, IREQ | IRW);
    step("lw_d", 1, 1, 3'd1, 8'h00);
    step("lw_e", 1, 1, 3'd2, 8'h00);
    step("lw_m0", 1, 0, 3'd3, DREQ);
    step("lw_m1", 1, 0, 3'd3, DREQ);
    step("lw_m2", 1, 0, 3'd3, DREQ);
    step("lw_m3", 1, 1, 3'd3, DREQ);
    step("lw_w", 1, 0, 3'd4, PCW | RFW | RET);

    // SW zero-wait
    set_dec(0, 0, 1, 0, 0, 0);
    step("sw_f", 1, 0, 3'd0, IREQ | IRW);
    step("sw_d", 1, 0, 3'd1, 8'h00);
    step("sw_e", 1, 0, 3'd2, 8'h00);
    step("sw_m", 1, 1, 3'd3, DREQ | DWE | PCW | RET);

    // BEQ retires from EXEC
    set_dec(0, 0, 0, 1, 0, 0);
    step("beq_f", 1, 0, 3'd0, IREQ | IRW);
    step("beq_d", 1, 0, 3'd1, 8'h00);
    step("beq_e", 1, 0, 3'd2, PCW | RET);

    // JAL to x0 after two fetch waits: WB without rf_write
    set_dec(0, 0, 0, 0, 1, 0);
    step("jal_fw0", 0, 0, 3'd0, IREQ);
    step("jal_fw1", 0, 0, 3'd0, IREQ);
    step("jal_f", 1, 0, 3'd0, IREQ | IRW);
    step("jal_d", 1, 0, 3'd1, 8'h00);
    step("jal_e", 1, 0, 3'd2, 8'h00);
    step("jal_w", 1, 0, 3'd4, PCW | RET);

    // Async reset while MEM waits
    set_dec(1, 1, 0, 0, 0, 0);
    step("ra_f", 1, 0, 3'd0, IREQ | IRW);
    step("ra_d", 1, 0, 3'd1, 8'h00);
    step("ra_e", 1, 0, 3'd2, 8'h00);
    step("ra_m", 0, 0, 3'd3, DREQ);
    do_reset("ra_async");
    step("ra_after", 0, 0, 3'd0, IREQ);

    // Illegal opcode locks into FAULT
    set_dec(0, 0, 0, 0, 0, 1);
    step("ill_f", 1, 0, 3'd0, IREQ | IRW);
    step("ill_d", 1, 1, 3'd1, 8'h00);
    for (int i = 0; i < 100; i++) step("ill_hold", 1, 1, 3'd5, FLT);
    do_reset("ill_rst");
    step("ill_post", 0, 0, 3'd0, IREQ);

    // Read and write both set is a decode fault
    set_dec(1, 1, 1, 0, 0, 0);
    step("rw_f", 1, 0, 3'd0, IREQ | IRW);
    step("rw_d", 1, 0, 3'd1, 8'h00);
    step("rw_flt0", 1, 1, 3'd5, FLT);
    step("rw_flt1", 1, 1, 3'd5, FLT);
    do_reset("rw_rst");

    // Fetch that never completes
    set_dec(0, 0, 0, 0, 0, 0);
`ifdef MC_BUS_TIMEOUT_EN
    for (int i = 0; i < 5; i++) step("tmo_wait", 0, 0, 3'd0, IREQ);
    step("tmo_flt", 0, 0, 3'd5, FLT);
`else
    for (int i = 0; i < 1000; i++) step("nowait", 0, 0, 3'd0, IREQ);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
